// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its prefetch queue.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0073;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned IFQ_PTR_W = $clog2(IFQ_DEPTH);

    typedef enum logic [1:0] {
        IFQ_RUN    = 2'd0,
        IFQ_DRAIN  = 2'd1,
        IFQ_HALTED = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// In-order prefetch queue: DEPTH entries of {instruction, pc}, head exposed
// combinationally so the fetch stage can present it with no extra cycle.
module ifq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  ifq_entry_t               push_entry,
    input  logic                     pop,
    output ifq_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ifq_entry_t       storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head_entry = storage[rd_ptr];

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch stage with credit-limited instruction-memory requests, stale-response
// dropping after redirects and a sticky halt on popping the halt encoding.
// Optional feature macro IFETCH_PERF_EN adds perf_fetched/perf_dropped/perf_stall.
module ifetch_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] PC,
    output logic        halt
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    ifq_state_e       state;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] stale;
    logic [CNT_W:0]   credit_used;
    logic             halt_seen;
    logic             halt_q;
    logic             redirect_eff;
    logic             req_fire;
    logic             rsp_drop;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [31:0]      rsp_pc;
    ifq_entry_t       push_entry;
    ifq_entry_t       head_entry;

    // Requests since the last redirect are consecutive words, so a kept
    // response belongs to the oldest of them: fetch_pc minus 4*outstanding.
    assign rsp_pc       = fetch_pc - (32'(outstanding) << 2);
    assign push_entry   = '{instr: imem_rsp_data, pc: rsp_pc};
    assign redirect_eff = redirect && (state != IFQ_HALTED);
    assign stale        = outstanding - CNT_W'(imem_rsp_valid);
    assign credit_used  = {1'b0, count} + {1'b0, outstanding};

    assign imem_req_valid = !rst && (state == IFQ_RUN) && !halt_seen && !redirect_eff
                            && (credit_used < DEPTH_L);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    assign push           = imem_rsp_valid && (drop_cnt == '0) && (state == IFQ_RUN) && !redirect_eff;
    assign head_valid     = (count != '0) && (state != IFQ_HALTED);
    assign pop            = head_valid && !stall && !redirect_eff;

    assign instr_valid = head_valid;
    assign instruction = head_valid ? head_entry.instr : NOP_INSTR;
    assign PC          = head_valid ? head_entry.pc : 32'h0000_0000;
    assign halt        = halt_q;

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_eff),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head_entry(head_entry),
        .count     (count)
    );

    // Fetch control: credit/drop counters, fetch address and RUN/DRAIN/HALTED FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IFQ_RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            halt_seen   <= 1'b0;
            halt_q      <= 1'b0;
        end else if (redirect_eff) begin
            state       <= (stale != '0) ? IFQ_DRAIN : IFQ_RUN;
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= stale;
            drop_cnt    <= stale;
            halt_seen   <= 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= stale + CNT_W'(req_fire);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push && (imem_rsp_data == HALT_INSTR)) begin
                halt_seen <= 1'b1;
            end
            case (state)
                IFQ_RUN: begin
                    if (pop && (head_entry.instr == HALT_INSTR)) begin
                        state  <= IFQ_HALTED;
                        halt_q <= 1'b1;
                    end
                end
                IFQ_DRAIN: begin
                    if (rsp_drop && (drop_cnt == CNT_W'(1))) begin
                        state <= IFQ_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    // Free-running event counters for pushes, discarded responses and stalled heads.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(push);
            perf_dropped <= perf_dropped + 32'(imem_rsp_valid && !push);
            perf_stall   <= perf_stall + 32'(instr_valid && stall);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: in-order memory model plus a
// queue-level reference of what the fetch stage must present to Dec.
module tb_ifetch_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] HALT_W   = 32'h0000_0073;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic        halt;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    ifetch_prefetch #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .HALT_INSTR(HALT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .PC            (PC),
        .halt          (halt)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped),
        .perf_stall    (perf_stall)
`endif
    );

    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { bit stall; bit exp_rv; logic [31:0] exp_addr; bit exp_iv; logic [31:0] exp_pc; } vec_t;

    pend_t       pending[$];
    ent_t        q_m[$];
    vec_t        vecs[11];

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          lat;
    int          rsp_prob;
    int          pushes_m;
    logic [31:0] halt_addr;
    logic [31:0] exp_fetch;
    bit          halt_seen_m;
    bit          halt_exp;
    bit          popped_last;
    logic [31:0] last_pop_pc;
    logic [31:0] halt_pop_pc;

    bit          drv_stall;
    bit          drv_redirect;
    bit          drv_ready;
    logic [31:0] drv_rpc;

    bit          s_rsp;
    bit          s_rv;
    logic [31:0] s_addr;
    bit          s_iv;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    bit          s_halt;
    bit          s_exp_iv;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == halt_addr) ? HALT_W : {a[23:0], 8'h33};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs against the queue-level reference before the edge.
    task automatic modelChecks();
        int  n_stale;
        bit  exp_rv;
        n_stale = 0;
        foreach (pending[i]) if (pending[i].stale) n_stale++;
        exp_rv = !halt_exp && !halt_seen_m && !drv_redirect && (n_stale == 0)
                 && (pending.size() + q_m.size() < DEPTH);
        s_exp_iv = (q_m.size() > 0) && !halt_exp;
        checkOutput("req_valid", 32'(s_rv), 32'(exp_rv));
        if (s_rv) checkOutput("req_addr", s_addr, exp_fetch);
        checkOutput("instr_valid", 32'(s_iv), 32'(s_exp_iv));
        if (s_exp_iv) begin
            checkOutput("head_pc", s_pc, q_m[0].pc);
            checkOutput("head_instr", s_instr, q_m[0].data);
        end else begin
            checkOutput("idle_pc", s_pc, 32'h0);
            checkOutput("idle_instr", s_instr, NOP_W);
        end
        checkOutput("halt", 32'(s_halt), 32'(halt_exp));
    endtask

    // Advance the reference by one clock using what was presented this cycle.
    task automatic modelUpdate();
        pend_t r;
        popped_last = 1'b0;
        if (drv_redirect && !halt_exp) begin
            if (s_rsp) void'(pending.pop_front());
            foreach (pending[i]) pending[i].stale = 1'b1;
            q_m.delete();
            halt_seen_m = 1'b0;
            exp_fetch   = {drv_rpc[31:2], 2'b00};
        end else begin
            if (s_exp_iv && !drv_stall) begin
                popped_last = 1'b1;
                last_pop_pc = q_m[0].pc;
                if (q_m[0].data == HALT_W) begin
                    halt_exp    = 1'b1;
                    halt_pop_pc = q_m[0].pc;
                end
                void'(q_m.pop_front());
            end
            if (s_rsp) begin
                r = pending.pop_front();
                if (!r.stale && !(halt_exp && !popped_last) && !(popped_last && halt_exp && last_pop_pc == halt_pop_pc && 1'b0)) begin
                    if (!halt_exp || (popped_last && last_pop_pc == halt_pop_pc)) begin
                        q_m.push_back('{pc: r.addr, data: memword(r.addr)});
                        pushes_m++;
                        if (memword(r.addr) == HALT_W) halt_seen_m = 1'b1;
                    end
                end
            end
            if (s_rv && drv_ready) begin
                pending.push_back('{addr: exp_fetch, due: cyc + lat, stale: 1'b0});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    endtask

    // One clock: drive Dec/memory inputs at negedge, check, then step the model.
    task automatic applyStimulus();
        @(negedge clk);
        rst            = 1'b0;
        stall          = drv_stall;
        redirect       = drv_redirect;
        redirect_pc    = drv_rpc;
        imem_req_ready = drv_ready;
        s_rsp = (pending.size() > 0) && (pending[0].due <= cyc)
                && (int'($urandom_range(99)) < rsp_prob);
        imem_rsp_valid = s_rsp;
        imem_rsp_data  = s_rsp ? memword(pending[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_rv    = imem_req_valid;
        s_addr  = imem_req_addr;
        s_iv    = instr_valid;
        s_pc    = PC;
        s_instr = instruction;
        s_halt  = halt;
        modelChecks();
        @(posedge clk);
        modelUpdate();
        cyc++;
    endtask

    // Synchronous reset; the memory model forgets every in-flight request.
    task automatic resetDut();
        @(negedge clk);
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instruction, NOP_W);
        checkOutput("rst_pc", PC, 32'h0);
        checkOutput("rst_halt", 32'(halt), 32'h0);
        pending.delete();
        q_m.delete();
        exp_fetch    = RESET_PC;
        halt_seen_m  = 1'b0;
        halt_exp     = 1'b0;
        popped_last  = 1'b0;
        cyc          = 0;
        pushes_m     = 0;
        drv_stall    = 1'b0;
        drv_redirect = 1'b0;
        drv_ready    = 1'b1;
        drv_rpc      = 32'h0;
    endtask

    initial begin
        bit          found;
        logic [31:0] a0;

        rst       = 1'b1;
        halt_addr = 32'h1;
        lat       = 1;
        rsp_prob  = 100;

        // Straight-line fetch, then a stall that fills the queue to its credit limit.
        vecs[0]  = '{0, 1, 32'h00, 0, 32'h00};
        vecs[1]  = '{0, 1, 32'h04, 0, 32'h00};
        vecs[2]  = '{0, 1, 32'h08, 1, 32'h00};
        vecs[3]  = '{0, 1, 32'h0C, 1, 32'h04};
        vecs[4]  = '{0, 1, 32'h10, 1, 32'h08};
        vecs[5]  = '{0, 1, 32'h14, 1, 32'h0C};
        vecs[6]  = '{1, 1, 32'h18, 1, 32'h10};
        vecs[7]  = '{1, 1, 32'h1C, 1, 32'h10};
        vecs[8]  = '{1, 0, 32'h00, 1, 32'h10};
        vecs[9]  = '{0, 0, 32'h00, 1, 32'h10};
        vecs[10] = '{0, 1, 32'h20, 1, 32'h14};

        resetDut();
        for (int i = 0; i < 11; i++) begin
            drv_stall = vecs[i].stall;
            applyStimulus();
            checkOutput("tbl_rv", 32'(s_rv), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) checkOutput("tbl_addr", s_addr, vecs[i].exp_addr);
            checkOutput("tbl_iv", 32'(s_iv), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                checkOutput("tbl_pc", s_pc, vecs[i].exp_pc);
                checkOutput("tbl_instr", s_instr, memword(vecs[i].exp_pc));
            end
        end

        // Long stall with 3-cycle memory: requests stop once credit is exhausted.
        resetDut();
        lat = 3;
        drv_stall = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("stall_req_off", 32'(s_rv), 32'h0);
        checkOutput("stall_head", s_pc, 32'h0);
        drv_stall = 1'b0;
        repeat (20) applyStimulus();

        // Redirect with two requests in flight: both responses are stale.
        resetDut();
        lat = 3;
        repeat (2) applyStimulus();
        drv_redirect = 1'b1;
        drv_rpc      = 32'h100;
        applyStimulus();
        checkOutput("redir_req_off", 32'(s_rv), 32'h0);
        drv_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus();
            if (s_iv) found = 1'b1;
        end
        checkOutput("redir_wait", 32'(found), 32'h1);
        checkOutput("redir_first_pc", s_pc, 32'h100);

        // Redirect in the same cycle as a response and a pop.
        resetDut();
        lat = 1;
        repeat (3) applyStimulus();
        drv_redirect = 1'b1;
        drv_rpc      = 32'h200;
        applyStimulus();
        checkOutput("pre_rsp", 32'(s_rsp), 32'h1);
        checkOutput("pre_iv", 32'(s_iv), 32'h1);
        drv_redirect = 1'b0;
        applyStimulus();
        checkOutput("redir_q_empty", 32'(s_iv), 32'h0);
        checkOutput("redir_rv", 32'(s_rv), 32'h1);
        checkOutput("redir_addr", s_addr, 32'h200);
        repeat (6) applyStimulus();

        // Branch at 0x1C redirects past the halt word at 0x20.
        resetDut();
        lat       = 2;
        halt_addr = 32'h20;
        found     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drv_redirect = popped_last && (last_pop_pc == 32'h1C);
            drv_rpc      = 32'h40;
            if (drv_redirect) found = 1'b1;
            applyStimulus();
        end
        drv_redirect = 1'b0;
        checkOutput("branch_taken", 32'(found), 32'h1);
        checkOutput("branch_no_halt", 32'(s_halt), 32'h0);

        // Same program without the branch: halt on popping 0x20.
        resetDut();
        lat       = 2;
        halt_addr = 32'h20;
        found     = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            applyStimulus();
            if (s_halt) found = 1'b1;
        end
        checkOutput("halt_set", 32'(found), 32'h1);
        checkOutput("halt_pop_pc", halt_pop_pc, 32'h20);
        drv_redirect = 1'b1;
        drv_rpc      = 32'h300;
        applyStimulus();
        drv_redirect = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("halt_sticky", 32'(s_halt), 32'h1);
        checkOutput("halt_req_off", 32'(s_rv), 32'h0);
        halt_addr = 32'h1;

        // Memory back-pressure: address must hold until accepted.
        resetDut();
        lat = 1;
        repeat (4) applyStimulus();
        drv_ready = 1'b0;
        applyStimulus();
        a0 = s_addr;
        repeat (4) begin
            applyStimulus();
            checkOutput("hold_valid", 32'(s_rv), 32'h1);
            checkOutput("hold_addr", s_addr, a0);
        end
        drv_ready = 1'b1;
        applyStimulus();
        checkOutput("resume_addr", s_addr, a0);
        applyStimulus();
        checkOutput("resume_next", s_addr, a0 + 32'd4);

        // Randomised traffic against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            resetDut();
            lat       = int'($urandom_range(1, 4));
            rsp_prob  = 60 + int'($urandom_range(0, 40));
            halt_addr = (seg % 2 == 1) ? (32'($urandom_range(4, 24)) << 2) : 32'h1;
            for (int c = 0; c < 400; c++) begin
                drv_ready    = ($urandom_range(99) < 75);
                drv_stall    = ($urandom_range(99) < 30);
                drv_redirect = ($urandom_range(99) < 4);
                drv_rpc      = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8
                                                        : (32'($urandom_range(0, 40)) << 2);
                applyStimulus();
            end
        end
        drv_redirect = 1'b0;

`ifdef IFETCH_PERF_EN
        checkOutput("perf_fetched", perf_fetched, 32'(pushes_m));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
